// File: rtl/tl_a_arbiter_2to1.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tl_a_arbiter_2to1
//
// Shares one downstream TileLink-UL A/D port between two uncached clients.
// The A channel is arbitrated combinationally. Multi-beat Put bursts lock the
// grant to their owner until the last beat has fired. The winning port index
// is prepended to the source field. D-channel beats are routed back to a
// client using that extra source MSB, and the MSB is stripped again on return.
//
// Configuration macro:
//   TL_ARB_ROUND_ROBIN_EN  defined     -> round-robin priority between ports
//                          not defined -> fixed priority, port 0 wins ties
//
// Ports:
//   clock, reset               sole clock (rising edge), sync active-high reset
//   in{0,1}_a_*                client A requests (valid/ready + payload)
//   in{0,1}_d_*                client D responses (valid/ready + payload)
//   out_a_*                    downstream A request, source is SRC_W+1 bits
//   out_d_*                    downstream D response, source MSB selects client
// -----------------------------------------------------------------------------
module tl_a_arbiter_2to1 #(
  parameter int BEAT_BYTES_LOG2 = 3,
  parameter int SRC_W           = 6
) (
  input  logic               clock,
  input  logic               reset,

  input  logic               in0_a_valid,
  output logic               in0_a_ready,
  input  logic [2:0]         in0_a_bits_opcode,
  input  logic [2:0]         in0_a_bits_param,
  input  logic [2:0]         in0_a_bits_size,
  input  logic [SRC_W-1:0]   in0_a_bits_source,
  input  logic [31:0]        in0_a_bits_address,
  input  logic [7:0]         in0_a_bits_mask,
  input  logic [63:0]        in0_a_bits_data,
  input  logic               in0_a_bits_corrupt,
  output logic               in0_d_valid,
  input  logic               in0_d_ready,
  output logic [2:0]         in0_d_bits_opcode,
  output logic [1:0]         in0_d_bits_param,
  output logic [2:0]         in0_d_bits_size,
  output logic [SRC_W-1:0]   in0_d_bits_source,
  output logic [2:0]         in0_d_bits_sink,
  output logic               in0_d_bits_denied,
  output logic [63:0]        in0_d_bits_data,
  output logic               in0_d_bits_corrupt,

  input  logic               in1_a_valid,
  output logic               in1_a_ready,
  input  logic [2:0]         in1_a_bits_opcode,
  input  logic [2:0]         in1_a_bits_param,
  input  logic [2:0]         in1_a_bits_size,
  input  logic [SRC_W-1:0]   in1_a_bits_source,
  input  logic [31:0]        in1_a_bits_address,
  input  logic [7:0]         in1_a_bits_mask,
  input  logic [63:0]        in1_a_bits_data,
  input  logic               in1_a_bits_corrupt,
  output logic               in1_d_valid,
  input  logic               in1_d_ready,
  output logic [2:0]         in1_d_bits_opcode,
  output logic [1:0]         in1_d_bits_param,
  output logic [2:0]         in1_d_bits_size,
  output logic [SRC_W-1:0]   in1_d_bits_source,
  output logic [2:0]         in1_d_bits_sink,
  output logic               in1_d_bits_denied,
  output logic [63:0]        in1_d_bits_data,
  output logic               in1_d_bits_corrupt,

  output logic               out_a_valid,
  input  logic               out_a_ready,
  output logic [2:0]         out_a_bits_opcode,
  output logic [2:0]         out_a_bits_param,
  output logic [2:0]         out_a_bits_size,
  output logic [SRC_W:0]     out_a_bits_source,
  output logic [31:0]        out_a_bits_address,
  output logic [7:0]         out_a_bits_mask,
  output logic [63:0]        out_a_bits_data,
  output logic               out_a_bits_corrupt,

  input  logic               out_d_valid,
  output logic               out_d_ready,
  input  logic [2:0]         out_d_bits_opcode,
  input  logic [1:0]         out_d_bits_param,
  input  logic [2:0]         out_d_bits_size,
  input  logic [SRC_W:0]     out_d_bits_source,
  input  logic [2:0]         out_d_bits_sink,
  input  logic               out_d_bits_denied,
  input  logic [63:0]        out_d_bits_data,
  input  logic               out_d_bits_corrupt
);

  localparam logic       ST_IDLE        = 1'b0;
  localparam logic       ST_LOCKED      = 1'b1;
  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] BEAT_SIZE      = 3'(BEAT_BYTES_LOG2);

  logic       locked;
  logic       owner;
  logic [7:0] beats_left;
  logic       prio;
  logic       winner;
  logic       a_fire;
  logic [7:0] msg_beats;
  logic       d_sel;

  // While a burst is in flight the owner keeps the grant; otherwise a lone
  // requester wins, and a tie is broken by the current priority holder.
  always_comb begin
    winner = 1'b0;
    if (locked == ST_LOCKED) begin
      winner = owner;
    end else if (in0_a_valid && in1_a_valid) begin
      winner = prio;
    end else if (in1_a_valid) begin
      winner = 1'b1;
    end
  end

  assign out_a_valid = winner ? in1_a_valid : in0_a_valid;
  assign in0_a_ready = out_a_ready & in0_a_valid & ~winner;
  assign in1_a_ready = out_a_ready & in1_a_valid &  winner;
  assign a_fire      = out_a_valid & out_a_ready;

  assign out_a_bits_opcode  = winner ? in1_a_bits_opcode  : in0_a_bits_opcode;
  assign out_a_bits_param   = winner ? in1_a_bits_param   : in0_a_bits_param;
  assign out_a_bits_size    = winner ? in1_a_bits_size    : in0_a_bits_size;
  assign out_a_bits_source  = {winner, (winner ? in1_a_bits_source : in0_a_bits_source)};
  assign out_a_bits_address = winner ? in1_a_bits_address : in0_a_bits_address;
  assign out_a_bits_mask    = winner ? in1_a_bits_mask    : in0_a_bits_mask;
  assign out_a_bits_data    = winner ? in1_a_bits_data    : in0_a_bits_data;
  assign out_a_bits_corrupt = winner ? in1_a_bits_corrupt : in0_a_bits_corrupt;

  // Only Puts carry data beats; anything wider than one beat is a burst of
  // 2^(size - BEAT_BYTES_LOG2) beats. Requests without data are one beat.
  always_comb begin
    msg_beats = 8'd1;
    if ((out_a_bits_opcode == OP_PUT_FULL || out_a_bits_opcode == OP_PUT_PARTIAL) &&
        (out_a_bits_size > BEAT_SIZE)) begin
      msg_beats = 8'd1 << (out_a_bits_size - BEAT_SIZE);
    end
  end

  // Burst lock: the first fired beat of a multi-beat Put latches the owner
  // and the remaining beat count, which then counts down one per fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      locked     <= ST_IDLE;
      owner      <= 1'b0;
      beats_left <= 8'd0;
    end else if (a_fire) begin
      if (locked == ST_LOCKED) begin
        beats_left <= beats_left - 8'd1;
        if (beats_left == 8'd1) begin
          locked <= ST_IDLE;
        end
      end else if (msg_beats != 8'd1) begin
        locked     <= ST_LOCKED;
        owner      <= winner;
        beats_left <= msg_beats - 8'd1;
      end
    end
  end

`ifdef TL_ARB_ROUND_ROBIN_EN
  logic last_beat;

  assign last_beat = (locked == ST_LOCKED) ? (beats_left == 8'd1) : (msg_beats == 8'd1);

  // Priority passes to the other port once a whole message has gone through,
  // so a port that just finished yields on the next tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (a_fire && last_beat) begin
      prio <= ~winner;
    end
  end
`else
  assign prio = 1'b0;
`endif

  // D is stateless: every beat is steered by its own source MSB, and the
  // payload fans out to both clients unchanged apart from the stripped MSB.
  assign d_sel       = out_d_bits_source[SRC_W];
  assign in0_d_valid = out_d_valid & ~d_sel;
  assign in1_d_valid = out_d_valid &  d_sel;
  assign out_d_ready = d_sel ? in1_d_ready : in0_d_ready;

  assign in0_d_bits_opcode  = out_d_bits_opcode;
  assign in0_d_bits_param   = out_d_bits_param;
  assign in0_d_bits_size    = out_d_bits_size;
  assign in0_d_bits_source  = out_d_bits_source[SRC_W-1:0];
  assign in0_d_bits_sink    = out_d_bits_sink;
  assign in0_d_bits_denied  = out_d_bits_denied;
  assign in0_d_bits_data    = out_d_bits_data;
  assign in0_d_bits_corrupt = out_d_bits_corrupt;

  assign in1_d_bits_opcode  = out_d_bits_opcode;
  assign in1_d_bits_param   = out_d_bits_param;
  assign in1_d_bits_size    = out_d_bits_size;
  assign in1_d_bits_source  = out_d_bits_source[SRC_W-1:0];
  assign in1_d_bits_sink    = out_d_bits_sink;
  assign in1_d_bits_denied  = out_d_bits_denied;
  assign in1_d_bits_data    = out_d_bits_data;
  assign in1_d_bits_corrupt = out_d_bits_corrupt;

endmodule

// File: tb/tb_tl_a_arbiter_2to1.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_tl_a_arbiter_2to1
//
// Directed scenarios for reset, routing, contention, burst locking and
// mid-burst reset, followed by randomized traffic on both clients and on the
// D channel. Expected beats are queued when issued; a negedge monitor pops
// and compares them whenever the arbiter presents a fired beat.
// -----------------------------------------------------------------------------
module tb_tl_a_arbiter_2to1;

  localparam int SRC_W           = 6;
  localparam int BEAT_BYTES_LOG2 = 3;
`ifdef TL_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [5:0]  source;
    logic [31:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } a_beat_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [2:0]  size;
    logic [5:0]  source;
    logic [2:0]  sink;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } d_payload_t;

  typedef struct packed {
    logic       port;
    logic       ready;
    d_payload_t pl;
  } d_exp_t;

  logic clock = 1'b0;
  logic reset;

  logic in0_a_valid, in0_a_ready, in0_a_bits_corrupt;
  logic [2:0] in0_a_bits_opcode, in0_a_bits_param, in0_a_bits_size;
  logic [SRC_W-1:0] in0_a_bits_source;
  logic [31:0] in0_a_bits_address;
  logic [7:0] in0_a_bits_mask;
  logic [63:0] in0_a_bits_data;
  logic in0_d_valid, in0_d_ready, in0_d_bits_denied, in0_d_bits_corrupt;
  logic [2:0] in0_d_bits_opcode, in0_d_bits_size, in0_d_bits_sink;
  logic [1:0] in0_d_bits_param;
  logic [SRC_W-1:0] in0_d_bits_source;
  logic [63:0] in0_d_bits_data;

  logic in1_a_valid, in1_a_ready, in1_a_bits_corrupt;
  logic [2:0] in1_a_bits_opcode, in1_a_bits_param, in1_a_bits_size;
  logic [SRC_W-1:0] in1_a_bits_source;
  logic [31:0] in1_a_bits_address;
  logic [7:0] in1_a_bits_mask;
  logic [63:0] in1_a_bits_data;
  logic in1_d_valid, in1_d_ready, in1_d_bits_denied, in1_d_bits_corrupt;
  logic [2:0] in1_d_bits_opcode, in1_d_bits_size, in1_d_bits_sink;
  logic [1:0] in1_d_bits_param;
  logic [SRC_W-1:0] in1_d_bits_source;
  logic [63:0] in1_d_bits_data;

  logic out_a_valid, out_a_ready, out_a_bits_corrupt;
  logic [2:0] out_a_bits_opcode, out_a_bits_param, out_a_bits_size;
  logic [SRC_W:0] out_a_bits_source;
  logic [31:0] out_a_bits_address;
  logic [7:0] out_a_bits_mask;
  logic [63:0] out_a_bits_data;
  logic out_d_valid, out_d_ready, out_d_bits_denied, out_d_bits_corrupt;
  logic [2:0] out_d_bits_opcode, out_d_bits_size, out_d_bits_sink;
  logic [1:0] out_d_bits_param;
  logic [SRC_W:0] out_d_bits_source;
  logic [63:0] out_d_bits_data;

  tl_a_arbiter_2to1 #(.BEAT_BYTES_LOG2(BEAT_BYTES_LOG2), .SRC_W(SRC_W)) dut (
    .clock(clock), .reset(reset),
    .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready),
    .in0_a_bits_opcode(in0_a_bits_opcode), .in0_a_bits_param(in0_a_bits_param),
    .in0_a_bits_size(in0_a_bits_size), .in0_a_bits_source(in0_a_bits_source),
    .in0_a_bits_address(in0_a_bits_address), .in0_a_bits_mask(in0_a_bits_mask),
    .in0_a_bits_data(in0_a_bits_data), .in0_a_bits_corrupt(in0_a_bits_corrupt),
    .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready),
    .in0_d_bits_opcode(in0_d_bits_opcode), .in0_d_bits_param(in0_d_bits_param),
    .in0_d_bits_size(in0_d_bits_size), .in0_d_bits_source(in0_d_bits_source),
    .in0_d_bits_sink(in0_d_bits_sink), .in0_d_bits_denied(in0_d_bits_denied),
    .in0_d_bits_data(in0_d_bits_data), .in0_d_bits_corrupt(in0_d_bits_corrupt),
    .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready),
    .in1_a_bits_opcode(in1_a_bits_opcode), .in1_a_bits_param(in1_a_bits_param),
    .in1_a_bits_size(in1_a_bits_size), .in1_a_bits_source(in1_a_bits_source),
    .in1_a_bits_address(in1_a_bits_address), .in1_a_bits_mask(in1_a_bits_mask),
    .in1_a_bits_data(in1_a_bits_data), .in1_a_bits_corrupt(in1_a_bits_corrupt),
    .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready),
    .in1_d_bits_opcode(in1_d_bits_opcode), .in1_d_bits_param(in1_d_bits_param),
    .in1_d_bits_size(in1_d_bits_size), .in1_d_bits_source(in1_d_bits_source),
    .in1_d_bits_sink(in1_d_bits_sink), .in1_d_bits_denied(in1_d_bits_denied),
    .in1_d_bits_data(in1_d_bits_data), .in1_d_bits_corrupt(in1_d_bits_corrupt),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_a_bits_opcode(out_a_bits_opcode), .out_a_bits_param(out_a_bits_param),
    .out_a_bits_size(out_a_bits_size), .out_a_bits_source(out_a_bits_source),
    .out_a_bits_address(out_a_bits_address), .out_a_bits_mask(out_a_bits_mask),
    .out_a_bits_data(out_a_bits_data), .out_a_bits_corrupt(out_a_bits_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
    .out_d_bits_opcode(out_d_bits_opcode), .out_d_bits_param(out_d_bits_param),
    .out_d_bits_size(out_d_bits_size), .out_d_bits_source(out_d_bits_source),
    .out_d_bits_sink(out_d_bits_sink), .out_d_bits_denied(out_d_bits_denied),
    .out_d_bits_data(out_d_bits_data), .out_d_bits_corrupt(out_d_bits_corrupt)
  );

  always #5 clock = ~clock;

  int pass_count = 0;
  int check_count = 0;
  bit rand_phase = 1'b0;

  a_beat_t a_q0[$];
  a_beat_t a_q1[$];
  d_exp_t  d_q[$];

  int   mon_remaining = 0;
  logic mon_port = 1'b0;
  logic mon_prio = 1'b0;

  int      msgs_left[2];
  int      beats_rem[2];
  int      beat_idx[2];
  int      stall[2];
  logic    cur_valid[2];
  a_beat_t cur_beat[2];
  a_beat_t msg_hdr[2];
  bit      timeout;
  logic    rdy;
  d_exp_t  d_stim;

  // Every comparison goes through here so pass and total counts stay in step.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    check_count++;
    if (act === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // A TileLink message moves size bytes; Puts carry that as data beats of
  // 2^BEAT_BYTES_LOG2 bytes each, everything else is a single beat.
  function automatic int msg_beats(input logic [2:0] op, input logic [2:0] sz);
    int bytes;
    int per_beat;
    bytes    = 1 << sz;
    per_beat = 1 << BEAT_BYTES_LOG2;
    if ((op == OP_PUT_FULL || op == OP_PUT_PART) && bytes > per_beat) return bytes / per_beat;
    return 1;
  endfunction

  task automatic applyStimulus(input int p, input logic v, input a_beat_t b);
    if (p == 0) begin
      in0_a_valid = v;
      {in0_a_bits_opcode, in0_a_bits_param, in0_a_bits_size, in0_a_bits_source,
       in0_a_bits_address, in0_a_bits_mask, in0_a_bits_data, in0_a_bits_corrupt} = b;
    end else begin
      in1_a_valid = v;
      {in1_a_bits_opcode, in1_a_bits_param, in1_a_bits_size, in1_a_bits_source,
       in1_a_bits_address, in1_a_bits_mask, in1_a_bits_data, in1_a_bits_corrupt} = b;
    end
  endtask

  task automatic setReq(input int p, input logic [2:0] op, input logic [2:0] sz, input logic [5:0] src);
    a_beat_t b;
    b = '0;
    b.opcode  = op;
    b.size    = sz;
    b.source  = src;
    b.address = 32'h1000 * 32'(p + 1);
    b.mask    = 8'hff;
    b.data    = {$urandom, $urandom};
    applyStimulus(p, 1'b1, b);
  endtask

  task automatic clearInputs();
    applyStimulus(0, 1'b0, '0);
    applyStimulus(1, 1'b0, '0);
    out_a_ready = 1'b0;
    out_d_valid = 1'b0;
    {out_d_bits_opcode, out_d_bits_param, out_d_bits_size, out_d_bits_source,
     out_d_bits_sink, out_d_bits_denied, out_d_bits_data, out_d_bits_corrupt} = '0;
    in0_d_ready = 1'b0;
    in1_d_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // A-channel monitor: each fired beat must be the next one issued by the
  // client it claims to come from, bursts must not interleave, and message
  // starts under contention must follow the priority rule.
  task automatic monitorA();
    a_beat_t got;
    a_beat_t want;
    logic    p;
    bit      have;
    p    = out_a_bits_source[SRC_W];
    got  = '{out_a_bits_opcode, out_a_bits_param, out_a_bits_size, out_a_bits_source[SRC_W-1:0],
             out_a_bits_address, out_a_bits_mask, out_a_bits_data, out_a_bits_corrupt};
    have = 1'b0;
    want = '0;
    if (p == 1'b0 && a_q0.size() > 0) begin
      want = a_q0.pop_front();
      have = 1'b1;
    end else if (p == 1'b1 && a_q1.size() > 0) begin
      want = a_q1.pop_front();
      have = 1'b1;
    end
    checkOutput("a_beat_was_issued", 128'(have), 128'(1'b1));
    if (have) begin
      checkOutput("a_payload", 128'(got), 128'(want));
      checkOutput("a_single_ready", 128'({in0_a_ready, in1_a_ready}), 128'(p ? 2'b01 : 2'b10));
      if (mon_remaining > 0) begin
        checkOutput("a_lock_owner", 128'(p), 128'(mon_port));
        mon_remaining--;
        if (mon_remaining == 0) mon_prio = ~p;
      end else begin
        if (in0_a_valid && in1_a_valid) begin
          checkOutput("a_arb_pick", 128'(p), 128'(RR_EN ? mon_prio : 1'b0));
        end
        if (msg_beats(want.opcode, want.size) > 1) begin
          mon_remaining = msg_beats(want.opcode, want.size) - 1;
          mon_port      = p;
        end else begin
          mon_prio = ~p;
        end
      end
    end
  endtask

  task automatic monitorD();
    d_exp_t     e;
    d_payload_t g0;
    d_payload_t g1;
    g0 = '{in0_d_bits_opcode, in0_d_bits_param, in0_d_bits_size, in0_d_bits_source,
           in0_d_bits_sink, in0_d_bits_denied, in0_d_bits_data, in0_d_bits_corrupt};
    g1 = '{in1_d_bits_opcode, in1_d_bits_param, in1_d_bits_size, in1_d_bits_source,
           in1_d_bits_sink, in1_d_bits_denied, in1_d_bits_data, in1_d_bits_corrupt};
    if (out_d_valid) begin
      checkOutput("d_was_issued", 128'(d_q.size() != 0), 128'(1'b1));
      if (d_q.size() != 0) begin
        e = d_q.pop_front();
        checkOutput("d_valid_route", 128'({in0_d_valid, in1_d_valid}), 128'(e.port ? 2'b01 : 2'b10));
        checkOutput("d_ready_route", 128'(out_d_ready), 128'(e.ready));
        checkOutput("d_payload_in0", 128'(g0), 128'(e.pl));
        checkOutput("d_payload_in1", 128'(g1), 128'(e.pl));
      end
    end else begin
      checkOutput("d_idle", 128'({in0_d_valid, in1_d_valid}), 128'(2'b00));
    end
  endtask

  always @(negedge clock) begin
    if (rand_phase) begin
      if (out_a_valid && out_a_ready) monitorA();
      monitorD();
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got time limit, want self-termination");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearInputs();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;

    // Reset state: nothing valid, nothing ready.
    @(negedge clock);
    checkOutput("rst_out_a_valid", 128'(out_a_valid), 128'(1'b0));
    checkOutput("rst_in_a_ready", 128'({in0_a_ready, in1_a_ready}), 128'(2'b00));
    checkOutput("rst_in_d_valid", 128'({in0_d_valid, in1_d_valid}), 128'(2'b00));
    checkOutput("rst_out_d_ready", 128'(out_d_ready), 128'(1'b0));

    // Single requester on port 1: source tagged with the port index.
    step();
    setReq(1, OP_GET, 3'd3, 6'h05);
    out_a_ready = 1'b1;
    @(negedge clock);
    checkOutput("single_out_valid", 128'(out_a_valid), 128'(1'b1));
    checkOutput("single_out_source", 128'(out_a_bits_source), 128'(7'h45));
    checkOutput("single_out_address", 128'(out_a_bits_address), 128'(32'h2000));
    checkOutput("single_ready", 128'({in0_a_ready, in1_a_ready}), 128'(2'b01));
    step();
    clearInputs();

    // D routed to port 1 by source MSB, MSB stripped.
    out_d_valid       = 1'b1;
    out_d_bits_source = 7'h45;
    out_d_bits_data   = 64'hdead_beef_0123_4567;
    in1_d_ready       = 1'b1;
    @(negedge clock);
    checkOutput("d1_valid", 128'({in0_d_valid, in1_d_valid}), 128'(2'b01));
    checkOutput("d1_source", 128'(in1_d_bits_source), 128'(6'h05));
    checkOutput("d1_data", 128'(in1_d_bits_data), 128'(64'hdead_beef_0123_4567));
    checkOutput("d1_out_ready", 128'(out_d_ready), 128'(1'b1));

    // D backpressure from port 0 while port 1 is ready.
    step();
    out_d_bits_source = 7'h05;
    in0_d_ready       = 1'b0;
    in1_d_ready       = 1'b1;
    @(negedge clock);
    checkOutput("d0_valid", 128'({in0_d_valid, in1_d_valid}), 128'(2'b10));
    checkOutput("d0_backpressure", 128'(out_d_ready), 128'(1'b0));
    step();
    clearInputs();

    // Contention after reset: three single-beat Gets each way.
    doReset();
    setReq(0, OP_GET, 3'd3, 6'h01);
    setReq(1, OP_GET, 3'd3, 6'h02);
    out_a_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput($sformatf("contend_grant_%0d", i), 128'(out_a_bits_source[SRC_W]),
                  128'(RR_EN ? 1'(i % 2) : 1'b0));
      step();
    end
    clearInputs();

    // Burst lock: 4-beat PutFull on port 0 blocks port 1 until done.
    doReset();
    setReq(0, OP_PUT_FULL, 3'd5, 6'h03);
    setReq(1, OP_GET, 3'd3, 6'h04);
    out_a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput($sformatf("lock_beat_%0d", i), 128'({in0_a_ready, in1_a_ready}), 128'(2'b10));
      step();
    end
    in0_a_valid = 1'b0;
    @(negedge clock);
    checkOutput("lock_release_in1", 128'(in1_a_ready), 128'(1'b1));
    checkOutput("lock_release_src", 128'(out_a_bits_source), 128'(7'h44));
    step();
    clearInputs();

    // Backpressure mid-burst: the remaining beat count must hold.
    doReset();
    setReq(0, OP_PUT_FULL, 3'd5, 6'h03);
    setReq(1, OP_GET, 3'd3, 6'h04);
    out_a_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      out_a_ready = (i < 2 || i >= 5);
      @(negedge clock);
      checkOutput($sformatf("bp_in1_blocked_%0d", i), 128'(in1_a_ready), 128'(1'b0));
      checkOutput($sformatf("bp_owner_%0d", i), 128'({out_a_valid, out_a_bits_source[SRC_W]}), 128'(2'b10));
      step();
    end
    in0_a_valid = 1'b0;
    @(negedge clock);
    checkOutput("bp_release_in1", 128'(in1_a_ready), 128'(1'b1));
    step();
    clearInputs();

    // Reset after two beats of a 4-beat Put releases the lock.
    doReset();
    setReq(0, OP_PUT_FULL, 3'd5, 6'h03);
    setReq(1, OP_GET, 3'd3, 6'h04);
    out_a_ready = 1'b1;
    repeat (2) step();
    doReset();
    @(negedge clock);
    checkOutput("rstmid_tie_port0", 128'(out_a_bits_source[SRC_W]), 128'(1'b0));
    #1;
    in0_a_valid = 1'b0;
    #1;
    checkOutput("rstmid_in1_grant", 128'(in1_a_ready), 128'(1'b1));
    step();
    clearInputs();

    // Randomized traffic on both clients and on D.
    doReset();
    mon_remaining = 0;
    mon_prio      = 1'b0;
    rand_phase    = 1'b1;
    for (int p = 0; p < 2; p++) begin
      msgs_left[p] = 25;
      beats_rem[p] = 0;
      beat_idx[p]  = 0;
      stall[p]     = 0;
      cur_valid[p] = 1'b0;
      cur_beat[p]  = '0;
      msg_hdr[p]   = '0;
    end
    timeout = 1'b0;
    while (!timeout && !(msgs_left[0] == 0 && msgs_left[1] == 0 && beats_rem[0] == 0 &&
                         beats_rem[1] == 0 && !cur_valid[0] && !cur_valid[1])) begin
      @(negedge clock);
      for (int p = 0; p < 2; p++) begin
        rdy = (p == 0) ? in0_a_ready : in1_a_ready;
        if (cur_valid[p]) begin
          if (rdy) begin
            cur_valid[p] = 1'b0;
            beats_rem[p]--;
            stall[p] = 0;
          end else begin
            stall[p]++;
            if (stall[p] > 200) begin
              checkOutput($sformatf("a_accept_timeout_port%0d", p), 128'(stall[p]), 128'(200));
              timeout = 1'b1;
            end
          end
        end
      end
      step();
      for (int p = 0; p < 2; p++) begin
        if (!cur_valid[p]) begin
          if (beats_rem[p] == 0 && msgs_left[p] > 0 && $urandom_range(0, 2) != 0) begin
            case ($urandom_range(0, 2))
              0:       msg_hdr[p].opcode = OP_PUT_FULL;
              1:       msg_hdr[p].opcode = OP_PUT_PART;
              default: msg_hdr[p].opcode = OP_GET;
            endcase
            msg_hdr[p].size    = 3'($urandom_range(0, 6));
            msg_hdr[p].param   = 3'd0;
            msg_hdr[p].source  = 6'($urandom);
            msg_hdr[p].address = $urandom & 32'hffff_ffc0;
            beats_rem[p] = msg_beats(msg_hdr[p].opcode, msg_hdr[p].size);
            beat_idx[p]  = 0;
            msgs_left[p]--;
          end
          if (beats_rem[p] > 0 && $urandom_range(0, 3) != 0) begin
            cur_beat[p]         = msg_hdr[p];
            cur_beat[p].address = msg_hdr[p].address + 32'(beat_idx[p] * 8);
            cur_beat[p].mask    = 8'($urandom);
            cur_beat[p].data    = {$urandom, $urandom};
            cur_beat[p].corrupt = 1'($urandom);
            beat_idx[p]++;
            cur_valid[p] = 1'b1;
            if (p == 0) a_q0.push_back(cur_beat[p]);
            else        a_q1.push_back(cur_beat[p]);
          end
        end
        applyStimulus(p, cur_valid[p], cur_beat[p]);
      end
      out_a_ready = ($urandom_range(0, 3) != 0);

      d_stim.port      = 1'($urandom);
      d_stim.pl        = '{3'($urandom), 2'($urandom), 3'($urandom), 6'($urandom),
                           3'($urandom), 1'($urandom), {$urandom, $urandom}, 1'($urandom)};
      in0_d_ready      = 1'($urandom);
      in1_d_ready      = 1'($urandom);
      d_stim.ready     = d_stim.port ? in1_d_ready : in0_d_ready;
      out_d_valid      = 1'($urandom);
      out_d_bits_opcode  = d_stim.pl.opcode;
      out_d_bits_param   = d_stim.pl.param;
      out_d_bits_size    = d_stim.pl.size;
      out_d_bits_source  = {d_stim.port, d_stim.pl.source};
      out_d_bits_sink    = d_stim.pl.sink;
      out_d_bits_denied  = d_stim.pl.denied;
      out_d_bits_data    = d_stim.pl.data;
      out_d_bits_corrupt = d_stim.pl.corrupt;
      if (out_d_valid) d_q.push_back(d_stim);
    end
    @(negedge clock);
    step();
    clearInputs();
    @(negedge clock);
    rand_phase = 1'b0;
    checkOutput("a_q0_drained", 128'(a_q0.size()), 128'(0));
    checkOutput("a_q1_drained", 128'(a_q1.size()), 128'(0));
    checkOutput("d_q_drained", 128'(d_q.size()), 128'(0));
    checkOutput("burst_closed", 128'(mon_remaining), 128'(0));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
